// File: rtl/mipi_pkg.sv
// Shared definitions for the MIPI RGB888 -> packed RGB565 pixel path:
// FSM state encodings, RGB565 field positions, the FIFO word layout and
// the pixel conversion helper.
package mipi_pkg;

    // Packer FSM state encodings
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_DROP   = 2'd2;

    // RGB888 bit ranges kept in the RGB565 result (truncation, no rounding)
    localparam int R_MSB = 23;
    localparam int R_LSB = 19;
    localparam int G_MSB = 15;
    localparam int G_LSB = 10;
    localparam int B_MSB = 7;
    localparam int B_LSB = 3;

    // One FIFO entry: two packed pixels plus frame markers (34 bits)
    typedef struct packed {
        logic        eop;
        logic        sop;
        logic [31:0] data;
    } fifo_word_t;

    // Truncating RGB888 -> RGB565 conversion
    function automatic logic [15:0] rgb888_to_565(input logic [23:0] pix);
        return {pix[R_MSB:R_LSB], pix[G_MSB:G_LSB], pix[B_MSB:B_LSB]};
    endfunction

endpackage

// File: rtl/mipi_pixel_fifo.sv
// Show-ahead synchronous FIFO holding packed pixel words with SOP/EOP.
// A write while full is accepted only when a read happens in the same cycle.
module mipi_pixel_fifo
    import mipi_pkg::*;
#(
    parameter int pDEPTH = 16
) (
    input  logic       iCLK,
    input  logic       iRESET,
    input  logic       iPUSH,
    input  fifo_word_t iWORD,
    input  logic       iPOP,
    output fifo_word_t oWORD,
    output logic       oFULL,
    output logic       oEMPTY
);

    localparam int AW = (pDEPTH > 1) ? $clog2(pDEPTH) : 1;

    fifo_word_t         mem_r [pDEPTH];
    logic [AW-1:0]      wr_ptr_r;
    logic [AW-1:0]      rd_ptr_r;
    logic [AW:0]        count_r;
    logic               full_s;
    logic               empty_s;
    logic               wr_en_s;
    logic               rd_en_s;

    assign full_s  = (count_r == (AW+1)'(pDEPTH));
    assign empty_s = (count_r == {(AW+1){1'b0}});
    assign rd_en_s = iPOP && !empty_s;
    assign wr_en_s = iPUSH && (!full_s || rd_en_s);

    assign oFULL  = full_s;
    assign oEMPTY = empty_s;

    // Storage array, no reset so it maps onto RAM
    always_ff @(posedge iCLK) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= iWORD;
        end
    end

    // Read/write pointers and occupancy count
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Show-ahead head of queue, forced to zero while empty
    always_comb begin
        oWORD = {$bits(fifo_word_t){1'b0}};
        if (empty_s) begin
            oWORD = {$bits(fifo_word_t){1'b0}};
        end else begin
            oWORD = mem_r[rd_ptr_r];
        end
    end

endmodule

// File: rtl/mipi_pixel_packer.sv
// Converts a MIPI RGB888 pixel stream to RGB565, pairs consecutive pixels
// into 32-bit words (earlier pixel in the low half) and queues them with
// frame start/end markers in a show-ahead FIFO toward a ready/valid sink.
module mipi_pixel_packer
    import mipi_pkg::*;
#(
    parameter int pWIDTH      = 640,
    parameter int pHEIGHT     = 480,
    parameter int pFIFO_DEPTH = 16
) (
    input  logic        iMIPI_CLK,
    input  logic        iRESET,
    input  logic [23:0] iMIPI_DATA,
    input  logic        iMIPI_START,
    input  logic        iMIPI_DATA_VALID,
    output logic [31:0] oDATA,
    output logic        oVALID,
    input  logic        iREADY,
    output logic        oSOP,
    output logic        oEOP,
    output logic        oOVERFLOW,
    output logic        oFRAME_DONE
);

    localparam int CW = (pWIDTH  > 1) ? $clog2(pWIDTH)  : 1;
    localparam int LW = (pHEIGHT > 1) ? $clog2(pHEIGHT) : 1;

    logic [1:0]     state_r;
    logic [CW-1:0]  col_r;
    logic [LW-1:0]  line_r;
    logic [15:0]    hold_r;
    logic           push_valid_r;
    fifo_word_t     push_word_r;
    logic           overflow_r;
    logic           frame_done_r;

    fifo_word_t     head_s;
    logic           full_s;
    logic           empty_s;
    logic           pop_s;
    logic           push_ok_s;
    logic           push_drop_s;
    logic           last_col_s;
    logic           last_line_s;

    assign pop_s       = !empty_s && iREADY;
    assign push_ok_s   = push_valid_r && (!full_s || pop_s);
    assign push_drop_s = push_valid_r && full_s && !pop_s;
    assign last_col_s  = (col_r  == CW'(pWIDTH - 1));
    assign last_line_s = (line_r == LW'(pHEIGHT - 1));

    // Frame FSM, pixel/line counters, pixel pairing and sticky status
    always_ff @(posedge iMIPI_CLK) begin
        if (iRESET) begin
            state_r      <= ST_IDLE;
            col_r        <= {CW{1'b0}};
            line_r       <= {LW{1'b0}};
            hold_r       <= 16'd0;
            push_valid_r <= 1'b0;
            push_word_r  <= {$bits(fifo_word_t){1'b0}};
            overflow_r   <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            push_valid_r <= 1'b0;
            frame_done_r <= push_ok_s && push_word_r.eop;
            if (push_drop_s) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end

            if (iMIPI_START) begin
                // New frame: restart geometry; a coincident pixel is discarded
                state_r <= ST_ACTIVE;
                col_r   <= {CW{1'b0}};
                line_r  <= {LW{1'b0}};
                hold_r  <= 16'd0;
            end else if (push_drop_s) begin
                state_r <= ST_DROP;
            end else begin
                case (state_r)
                    ST_ACTIVE: begin
                        if (iMIPI_DATA_VALID) begin
                            if (col_r[0] == 1'b0) begin
                                hold_r <= rgb888_to_565(iMIPI_DATA);
                            end else begin
                                push_valid_r     <= 1'b1;
                                push_word_r.data <= {rgb888_to_565(iMIPI_DATA), hold_r};
                                push_word_r.sop  <= (line_r == {LW{1'b0}}) && (col_r == CW'(1));
                                push_word_r.eop  <= last_col_s && last_line_s;
                            end
                            if (last_col_s) begin
                                col_r <= {CW{1'b0}};
                                if (last_line_s) begin
                                    line_r  <= {LW{1'b0}};
                                    state_r <= ST_IDLE;
                                end else begin
                                    line_r <= line_r + LW'(1);
                                end
                            end else begin
                                col_r <= col_r + CW'(1);
                            end
                        end
                    end
                    ST_IDLE: begin
                        state_r <= ST_IDLE;
                    end
                    ST_DROP: begin
                        state_r <= ST_DROP;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    mipi_pixel_fifo #(
        .pDEPTH (pFIFO_DEPTH)
    ) u_fifo (
        .iCLK   (iMIPI_CLK),
        .iRESET (iRESET),
        .iPUSH  (push_valid_r),
        .iWORD  (push_word_r),
        .iPOP   (pop_s),
        .oWORD  (head_s),
        .oFULL  (full_s),
        .oEMPTY (empty_s)
    );

    assign oDATA       = head_s.data;
    assign oSOP        = head_s.sop;
    assign oEOP        = head_s.eop;
    assign oVALID      = !empty_s;
    assign oOVERFLOW   = overflow_r;
    assign oFRAME_DONE = frame_done_r;

endmodule

// File: tb/tb_mipi_pixel_packer.sv
// Self-checking bench for mipi_pixel_packer on a 4x2 frame with a 16-word FIFO.
// A frame-level reference model predicts the word stream; a monitor compares
// every delivered word and checks stability while stalled.
module tb_mipi_pixel_packer;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int D    = 16;
    localparam int NPIX = W * H;

    logic        clk = 1'b0;
    logic        iRESET;
    logic [23:0] iMIPI_DATA;
    logic        iMIPI_START;
    logic        iMIPI_DATA_VALID;
    logic [31:0] oDATA;
    logic        oVALID;
    logic        iREADY;
    logic        oSOP;
    logic        oEOP;
    logic        oOVERFLOW;
    logic        oFRAME_DONE;

    int err_cnt = 0;
    int chk_cnt = 0;
    int fd_cnt  = 0;

    logic [33:0] exp_q [$];
    logic [33:0] got_q [$];

    bit          rdy      = 1'b1;
    bit          rand_rdy = 1'b0;
    bit          m_active = 1'b0;
    int          m_idx    = 0;
    logic [15:0] m_hold   = 16'd0;
    bit          stall_r  = 1'b0;
    logic [33:0] stall_word;

    always #5 clk = ~clk;

    mipi_pixel_packer #(
        .pWIDTH      (W),
        .pHEIGHT     (H),
        .pFIFO_DEPTH (D)
    ) dut (
        .iMIPI_CLK        (clk),
        .iRESET           (iRESET),
        .iMIPI_DATA       (iMIPI_DATA),
        .iMIPI_START      (iMIPI_START),
        .iMIPI_DATA_VALID (iMIPI_DATA_VALID),
        .oDATA            (oDATA),
        .oVALID           (oVALID),
        .iREADY           (iREADY),
        .oSOP             (oSOP),
        .oEOP             (oEOP),
        .oOVERFLOW        (oOVERFLOW),
        .oFRAME_DONE      (oFRAME_DONE)
    );

    function automatic logic [15:0] to565(input logic [23:0] p);
        return {p[23:19], p[15:10], p[7:3]};
    endfunction

    // Reference model: frame position as a flat pixel index, words queued in order
    task automatic model_pixel(input logic st, input logic vl, input logic [23:0] px);
        logic [33:0] w;
        if (st) begin
            m_active = 1'b1;
            m_idx    = 0;
        end else if (vl && m_active) begin
            if (m_idx % 2 == 0) begin
                m_hold = to565(px);
                m_idx++;
            end else begin
                w = {(m_idx == NPIX - 1), (m_idx == 1), to565(px), m_hold};
                if (exp_q.size() >= D && !rdy) begin
                    m_active = 1'b0;
                end else begin
                    exp_q.push_back(w);
                    m_idx++;
                end
            end
            if (m_idx == NPIX) m_active = 1'b0;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_active = 1'b0;
        m_idx    = 0;
    endtask

    task automatic drv(input logic st, input logic vl, input logic [23:0] px);
        @(posedge clk);
        #1;
        if (rand_rdy) rdy = 1'($urandom_range(0, 1));
        iMIPI_START      = st;
        iMIPI_DATA_VALID = vl;
        iMIPI_DATA       = px;
        iREADY           = rdy;
        model_pixel(st, vl, px);
    endtask

    task automatic idle(input int n);
        repeat (n) drv(1'b0, 1'b0, 24'h0);
    endtask

    task automatic send_frame(input int npix);
        drv(1'b1, 1'b0, 24'h0);
        for (int i = 0; i < npix; i++) drv(1'b0, 1'b1, 24'($urandom));
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 300 && (exp_q.size() != 0 || oVALID); i++) drv(1'b0, 1'b0, 24'h0);
        idle(3);
        chk_cnt++;
        if (exp_q.size() != 0 || oVALID !== 1'b0) begin
            err_cnt++;
            $display("FAIL %s_drain: pending=%0d oVALID=%b required pending=0 oVALID=0", name, exp_q.size(), oVALID);
        end
    endtask

    // Monitor: every transferred word against the model, stability while stalled
    always @(negedge clk) begin
        if (iRESET === 1'b0) begin
            if (oFRAME_DONE === 1'b1) fd_cnt++;
            if (stall_r && oVALID === 1'b1) begin
                chk_cnt++;
                if ({oEOP, oSOP, oDATA} !== stall_word) begin
                    err_cnt++;
                    $display("FAIL stall_hold: got %h required %h", {oEOP, oSOP, oDATA}, stall_word);
                end
            end
            if (oVALID === 1'b1 && iREADY === 1'b1) begin
                got_q.push_back({oEOP, oSOP, oDATA});
                chk_cnt++;
                if (exp_q.size() == 0) begin
                    err_cnt++;
                    $display("FAIL word_unexpected: got %h required none", {oEOP, oSOP, oDATA});
                end else begin
                    if ({oEOP, oSOP, oDATA} !== exp_q[0]) begin
                        err_cnt++;
                        $display("FAIL word_data: got %h required %h", {oEOP, oSOP, oDATA}, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
            end
            stall_r    = (oVALID === 1'b1) && (iREADY === 1'b0);
            stall_word = {oEOP, oSOP, oDATA};
        end else begin
            stall_r = 1'b0;
        end
    end

    task automatic test_reset();
        iRESET = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_cnt++;
        if ({oVALID, oSOP, oEOP, oOVERFLOW, oFRAME_DONE} !== 5'b00000) begin
            err_cnt++;
            $display("FAIL reset_flags: got %b required 00000", {oVALID, oSOP, oEOP, oOVERFLOW, oFRAME_DONE});
        end
        chk_cnt++;
        if (oDATA !== 32'h0) begin
            err_cnt++;
            $display("FAIL reset_data: got %h required 00000000", oDATA);
        end
        @(posedge clk);
        #1;
        iRESET = 1'b0;
        model_reset();
    endtask

    task automatic test_basic();
        logic [23:0] px [8];
        px = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF,
               24'h123456, 24'hABCDEF, 24'h808080, 24'h7F7F7F};
        rdy = 1'b1;
        got_q.delete();
        fd_cnt = 0;
        drv(1'b1, 1'b0, 24'h0);
        for (int i = 0; i < 8; i++) drv(1'b0, 1'b1, px[i]);
        wait_drain("basic");
        chk_cnt++;
        if (got_q.size() != 4) begin
            err_cnt++;
            $display("FAIL basic_count: got %0d required 4", got_q.size());
        end else begin
            chk_cnt++;
            if (got_q[0] !== {2'b01, 32'h07E0F800}) begin
                err_cnt++;
                $display("FAIL basic_first: got %h required %h", got_q[0], {2'b01, 32'h07E0F800});
            end
            chk_cnt++;
            if (got_q[1] !== {2'b00, 32'hFFFF001F}) begin
                err_cnt++;
                $display("FAIL basic_second: got %h required %h", got_q[1], {2'b00, 32'hFFFF001F});
            end
            chk_cnt++;
            if (got_q[3][33:32] !== 2'b10) begin
                err_cnt++;
                $display("FAIL basic_eop: got %b required 10", got_q[3][33:32]);
            end
        end
        chk_cnt++;
        if (fd_cnt != 1) begin
            err_cnt++;
            $display("FAIL basic_frame_done: got %0d pulses required 1", fd_cnt);
        end
    endtask

    task automatic test_start_collision();
        logic [23:0] p0;
        logic [23:0] p1;
        p0 = 24'($urandom);
        p1 = 24'($urandom);
        got_q.delete();
        drv(1'b1, 1'b1, 24'h123456);
        drv(1'b0, 1'b1, p0);
        drv(1'b0, 1'b1, p1);
        for (int i = 0; i < 6; i++) drv(1'b0, 1'b1, 24'($urandom));
        wait_drain("collision");
        chk_cnt++;
        if (got_q.size() != 4) begin
            err_cnt++;
            $display("FAIL collision_count: got %0d required 4", got_q.size());
        end else begin
            chk_cnt++;
            if (got_q[0] !== {2'b01, to565(p1), to565(p0)}) begin
                err_cnt++;
                $display("FAIL collision_first: got %h required %h", got_q[0], {2'b01, to565(p1), to565(p0)});
            end
        end
    endtask

    task automatic test_truncate();
        got_q.delete();
        fd_cnt = 0;
        send_frame(3);
        send_frame(NPIX);
        wait_drain("truncate");
        chk_cnt++;
        if (got_q.size() != 5) begin
            err_cnt++;
            $display("FAIL truncate_count: got %0d required 5", got_q.size());
        end else begin
            chk_cnt++;
            if (got_q[0][33:32] !== 2'b01 || got_q[1][33:32] !== 2'b01) begin
                err_cnt++;
                $display("FAIL truncate_markers: got %b/%b required 01/01", got_q[0][33:32], got_q[1][33:32]);
            end
        end
        chk_cnt++;
        if (fd_cnt != 1) begin
            err_cnt++;
            $display("FAIL truncate_frame_done: got %0d pulses required 1", fd_cnt);
        end
    endtask

    task automatic test_random_ready();
        got_q.delete();
        fd_cnt   = 0;
        rand_rdy = 1'b1;
        for (int f = 0; f < 2; f++) begin
            drv(1'b1, 1'b0, 24'h0);
            for (int i = 0; i < NPIX; i++) begin
                idle($urandom_range(0, 2));
                drv(1'b0, 1'b1, 24'($urandom));
            end
        end
        wait_drain("random_ready");
        rand_rdy = 1'b0;
        rdy      = 1'b1;
        chk_cnt++;
        if (got_q.size() != 8 || fd_cnt != 2) begin
            err_cnt++;
            $display("FAIL random_ready_count: got %0d words %0d done required 8 words 2 done", got_q.size(), fd_cnt);
        end
    endtask

    task automatic test_overflow();
        got_q.delete();
        rdy = 1'b0;
        for (int f = 0; f < 5; f++) send_frame(NPIX);
        idle(3);
        chk_cnt++;
        if (oOVERFLOW !== 1'b1 || oVALID !== 1'b1 || got_q.size() != 0) begin
            err_cnt++;
            $display("FAIL overflow_flag: got ovf=%b valid=%b words=%0d required 1 1 0", oOVERFLOW, oVALID, got_q.size());
        end
        rdy = 1'b1;
        wait_drain("overflow");
        chk_cnt++;
        if (got_q.size() != 16) begin
            err_cnt++;
            $display("FAIL overflow_buffered: got %0d required 16", got_q.size());
        end else begin
            chk_cnt++;
            if (got_q[12][32] !== 1'b1 || got_q[15][33] !== 1'b1) begin
                err_cnt++;
                $display("FAIL overflow_markers: got sop=%b eop=%b required 1 1", got_q[12][32], got_q[15][33]);
            end
        end
        send_frame(NPIX);
        wait_drain("overflow_resume");
        chk_cnt++;
        if (got_q.size() != 20 || oOVERFLOW !== 1'b1) begin
            err_cnt++;
            $display("FAIL overflow_resume: got %0d words ovf=%b required 20 words ovf=1", got_q.size(), oOVERFLOW);
        end else begin
            chk_cnt++;
            if (got_q[16][32] !== 1'b1) begin
                err_cnt++;
                $display("FAIL overflow_resume_sop: got %b required 1", got_q[16][32]);
            end
        end
    endtask

    task automatic test_reset_midqueue();
        got_q.delete();
        rdy = 1'b0;
        send_frame(NPIX);
        send_frame(2);
        idle(3);
        @(posedge clk);
        #1;
        iRESET = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        iRESET = 1'b0;
        chk_cnt++;
        if (oVALID !== 1'b0 || oOVERFLOW !== 1'b0) begin
            err_cnt++;
            $display("FAIL midreset_clear: got valid=%b ovf=%b required 0 0", oVALID, oOVERFLOW);
        end
        rdy = 1'b1;
        for (int i = 0; i < NPIX; i++) drv(1'b0, 1'b1, 24'($urandom));
        idle(5);
        chk_cnt++;
        if (got_q.size() != 0 || oVALID !== 1'b0) begin
            err_cnt++;
            $display("FAIL midreset_ignore: got %0d words valid=%b required 0 0", got_q.size(), oVALID);
        end
        send_frame(NPIX);
        wait_drain("midreset");
        chk_cnt++;
        if (got_q.size() != 4 || got_q[0][32] !== 1'b1) begin
            err_cnt++;
            $display("FAIL midreset_resume: got %0d words required 4 with SOP first", got_q.size());
        end
    endtask

    initial begin
        iRESET           = 1'b1;
        iMIPI_START      = 1'b0;
        iMIPI_DATA_VALID = 1'b0;
        iMIPI_DATA       = 24'h0;
        iREADY           = 1'b1;
        test_reset();
        test_basic();
        test_start_collision();
        test_truncate();
        test_random_ready();
        test_overflow();
        test_reset_midqueue();
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/mipi_pixel_packer.md
MIPI_PIXEL_PACKER -- requirements
Module: mipi_pixel_packer

Interface
REQ-001 The parameter pWIDTH SHALL default to 640 and SHALL give the active pixels per line; the value SHALL be even.
REQ-002 The parameter pHEIGHT SHALL default to 480 and SHALL give the active lines per frame.
REQ-003 The parameter pFIFO_DEPTH SHALL default to 16 and SHALL give the output FIFO depth in 32-bit words; the value SHALL be a power of 2.
REQ-004 iMIPI_CLK  in  1  SHALL be the single clock; all logic SHALL run on its rising edge.
REQ-005 iRESET  in  1  SHALL be the reset: synchronous, active-high.
REQ-006 iMIPI_DATA  in  24  SHALL carry the RGB888 pixel {R[23:16],G[15:8],B[7:0]} from the MIPI receiver.
REQ-007 iMIPI_START  in  1  SHALL be the frame-start (vsync) indication from the receiver.
REQ-008 iMIPI_DATA_VALID  in  1  SHALL be the per-pixel valid; it has no backpressure.
REQ-009 oDATA  out  32  SHALL carry two packed RGB565 pixels: the earlier pixel in [15:0] and the later pixel in [31:16].
REQ-010 oVALID  out  1  SHALL indicate that oDATA, oSOP and oEOP are valid.
REQ-011 iREADY  in  1  SHALL be the downstream accept; a word transfers on oVALID&iREADY.
REQ-012 oSOP / oEOP  out  1 each  SHALL mark the first and last word of a frame.
REQ-013 oOVERFLOW  out  1  SHALL be a sticky flag recording a FIFO overflow.
REQ-014 oFRAME_DONE  out  1  SHALL be a one-cycle pulse when a frame's last word is pushed.

Function
REQ-015 Pixel conversion SHALL be RGB565 = {R[7:3],G[7:2],B[7:3]}, with truncation and no rounding.
REQ-016 The state machine SHALL have three states:
- IDLE: on iMIPI_START go to ACTIVE.
- ACTIVE: accept pixels; after the last pixel (col pWIDTH-1, line pHEIGHT-1) go to IDLE.
- DROP: discard all pixels until iMIPI_START.
REQ-017 iMIPI_START SHALL, in any state, go to ACTIVE and clear the column counter, line counter and half-word holding register.
REQ-018 A pixel valid that coincides with iMIPI_START SHALL be discarded.
REQ-019 In ACTIVE, each valid SHALL advance the column counter (0..pWIDTH-1); wrap from pWIDTH-1 to 0 SHALL increment the line counter.
REQ-020 Pixels with an even column SHALL be held; pixels with an odd column SHALL complete the word, which is pushed into the FIFO on the next edge.
REQ-021 Valids received in IDLE (surplus after the frame) or in DROP SHALL be ignored.
REQ-022 oSOP SHALL accompany the word containing pixel (0,0); oEOP SHALL accompany the word containing pixel (pWIDTH-1,pHEIGHT-1).
REQ-023 oFRAME_DONE SHALL pulse in the cycle that the EOP word is pushed.
REQ-024 Latency: the odd pixel sampled at edge N SHALL make the word visible on oDATA/oVALID after edge N+1 if the FIFO was empty.
REQ-025 The FIFO SHALL be show-ahead; oVALID SHALL equal not-empty.
REQ-026 oDATA, oSOP and oEOP SHALL hold stable while oVALID&!iREADY.
REQ-027 A push while the FIFO is full and not popping in the same cycle SHALL drop the word, set oOVERFLOW, and go to DROP.
REQ-028 A push while full with a simultaneous pop SHALL succeed.
REQ-029 A simultaneous push and pop on an empty FIFO SHALL be impossible, because of show-ahead.
REQ-030 A frame truncated by an early iMIPI_START SHALL emit no EOP; the new frame SHALL restart with SOP.
REQ-031 oOVERFLOW SHALL clear only on iRESET.

Reset
REQ-032 When iRESET is asserted, the block SHALL enter IDLE, clear all counters and the holding register, and empty the FIFO.
REQ-033 While iRESET is asserted, oVALID, oSOP, oEOP, oOVERFLOW and oFRAME_DONE SHALL be 0.
REQ-034 When iRESET is asserted, oDATA SHALL be 0.
REQ-035 A reset mid-frame SHALL discard all partial data; the next output SHALL follow the next iMIPI_START.

Structure
REQ-036 The state encodings (IDLE=0, ACTIVE=1, DROP=2) and the RGB565 field positions SHALL be defined in a shared package, mipi_pkg.
REQ-037 The FIFO SHALL be a sub-module, mipi_pixel_fifo: 34 bits wide (data+SOP+EOP), pFIFO_DEPTH deep, show-ahead, with full/empty flags, synchronous reset, and inferred RAM.

Verification
REQ-038 (pWIDTH=4, pHEIGHT=2, iREADY=1) START, then 8 valids with pixels 0xFF0000, 0x00FF00, 0x0000FF, 0xFFFFFF, ... -> first word 0x07E0F800 with SOP; the fourth word has EOP; oFRAME_DONE is one pulse.
REQ-039 START and valid in the same cycle with pixel 0x123456 -> pixel discarded; the first word pairs the next two pixels.
REQ-040 iREADY=0, depth 16, a full 640x480 frame -> 16 words buffered, then oOVERFLOW=1, DROP, no further pushes; the next START resumes with SOP.
REQ-041 START after 3 pixels of a 4x2 frame -> 1 word output without EOP; the new frame restarts at (0,0) with SOP.
REQ-042 iRESET pulse while 5 words are queued -> oVALID=0 on the next cycle; subsequent valids are ignored until START.
REQ-043 Random iREADY toggling over a 4x2 frame -> data stable while stalled; exactly 4 words delivered in order.
